// File: rtl/alu_mem_datapath_pkg.sv
// Shared definitions for the 16-bit core datapath: the ALU opcode encoding.
package alu_mem_datapath_pkg;

  typedef enum logic [3:0] {
    A_ZERO  = 4'd0,
    A_PASSA = 4'd1,
    A_PASSB = 4'd2,
    A_ADD   = 4'd3,
    A_SUB   = 4'd4,
    A_AND   = 4'd5,
    A_OR    = 4'd6,
    A_XOR   = 4'd7,
    A_NOT   = 4'd8,
    A_INC   = 4'd9,
    A_DEC   = 4'd10,
    A_SHL   = 4'd11,
    A_SHR   = 4'd12,
    A_SRA   = 4'd13,
    A_NEG   = 4'd14,
    A_ONES  = 4'd15
  } alu_op_t;

endpackage

// File: rtl/dp_alu.sv
// Combinational 16-function ALU. Results wrap modulo 2**WIDTH; shifts are by one bit.
module dp_alu
  import alu_mem_datapath_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [3:0]       i_op,
  output logic [WIDTH-1:0] o_y,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_err,
  output logic             o_eq
);

  localparam int MSB = WIDTH - 1;

  alu_op_t          w_op;
  logic [WIDTH:0]   w_ext;

  assign w_op = alu_op_t'(i_op);

  always_comb begin
    w_ext   = '0;
    o_y     = '0;
    o_carry = 1'b0;
    o_ovf   = 1'b0;
    unique case (w_op)
      A_ZERO:  o_y = '0;
      A_PASSA: o_y = i_a;
      A_PASSB: o_y = i_b;
      A_ADD: begin
        w_ext   = {1'b0, i_a} + {1'b0, i_b};
        o_y     = w_ext[MSB:0];
        o_carry = w_ext[WIDTH];
        o_ovf   = (i_a[MSB] == i_b[MSB]) && (o_y[MSB] != i_a[MSB]);
      end
      A_SUB: begin
        // carry reports a borrow for the subtracting ops
        w_ext   = {1'b0, i_a} - {1'b0, i_b};
        o_y     = w_ext[MSB:0];
        o_carry = w_ext[WIDTH];
        o_ovf   = (i_a[MSB] != i_b[MSB]) && (o_y[MSB] != i_a[MSB]);
      end
      A_AND:   o_y = i_a & i_b;
      A_OR:    o_y = i_a | i_b;
      A_XOR:   o_y = i_a ^ i_b;
      A_NOT:   o_y = ~i_a;
      A_INC: begin
        w_ext   = {1'b0, i_a} + (WIDTH+1)'(1);
        o_y     = w_ext[MSB:0];
        o_carry = w_ext[WIDTH];
        o_ovf   = ~i_a[MSB] & o_y[MSB];
      end
      A_DEC: begin
        w_ext   = {1'b0, i_a} - (WIDTH+1)'(1);
        o_y     = w_ext[MSB:0];
        o_carry = w_ext[WIDTH];
        o_ovf   = i_a[MSB] & ~o_y[MSB];
      end
      A_SHL: begin
        o_y     = {i_a[MSB-1:0], 1'b0};
        o_carry = i_a[MSB];
      end
      A_SHR:   o_y = {1'b0, i_a[MSB:1]};
      A_SRA:   o_y = {i_a[MSB], i_a[MSB:1]};
      A_NEG: begin
        w_ext   = (WIDTH+1)'(0) - {1'b0, i_a};
        o_y     = w_ext[MSB:0];
        o_carry = w_ext[WIDTH];
        o_ovf   = i_a[MSB] & o_y[MSB];
      end
      A_ONES:  o_y = '1;
      default: o_y = '0;
    endcase
  end

  // Error: result out of range in either the unsigned or the signed view.
  assign o_err = o_carry | o_ovf;
  assign o_eq  = (i_a == i_b);

endmodule

// File: rtl/alu_mem_datapath.sv
// Core datapath: register file, word-addressed data memory, ALU and write-back mux.
module alu_mem_datapath
  import alu_mem_datapath_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int D_ADDR_W = 8,
  parameter int R_ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [D_ADDR_W-1:0] D_addr,
  input  logic [R_ADDR_W-1:0] RF_W_addr,
  input  logic [R_ADDR_W-1:0] RF_A_addr,
  input  logic [R_ADDR_W-1:0] RF_B_addr,
  input  logic                D_wr,
  input  logic                RF_s,
  input  logic                RF_W_en,
  input  logic [3:0]          ALU_sel,
  output logic [WIDTH-1:0]    ALU_A,
  output logic [WIDTH-1:0]    ALU_B,
  output logic [WIDTH-1:0]    ALU_Out
);

  localparam int R_DEPTH = 1 << R_ADDR_W;
  localparam int D_DEPTH = 1 << D_ADDR_W;

  logic [WIDTH-1:0] r_rf  [R_DEPTH];
  logic [WIDTH-1:0] r_mem [D_DEPTH];

  logic [WIDTH-1:0] w_mem_rd;
  logic [WIDTH-1:0] w_rf_wd;
  logic [3:0]       w_alu_flags_unused;

  assign ALU_A    = r_rf[RF_A_addr];
  assign ALU_B    = r_rf[RF_B_addr];
  assign w_mem_rd = r_mem[D_addr];
  assign w_rf_wd  = RF_s ? ALU_Out : w_mem_rd;

  dp_alu #(.WIDTH(WIDTH)) u_alu (
    .i_a     (ALU_A),
    .i_b     (ALU_B),
    .i_op    (ALU_sel),
    .o_y     (ALU_Out),
    .o_carry (w_alu_flags_unused[0]),
    .o_ovf   (w_alu_flags_unused[1]),
    .o_err   (w_alu_flags_unused[2]),
    .o_eq    (w_alu_flags_unused[3])
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < R_DEPTH; i++) r_rf[i] <= '0;
    end else if (RF_W_en) begin
      r_rf[RF_W_addr] <= w_rf_wd;
    end
  end

  // Memory keeps its contents through reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (rst_n && D_wr) r_mem[D_addr] <= ALU_A;
  end

endmodule

// File: tb/tb_alu_mem_datapath.sv
// Directed plan plus random cycles, checked against an arithmetic model of rf/mem/ALU.
module tb_alu_mem_datapath;

  localparam int W = 4;
  localparam int M = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] D_addr;
  logic [1:0] RF_W_addr, RF_A_addr, RF_B_addr;
  logic       D_wr, RF_s, RF_W_en;
  logic [3:0] ALU_sel;
  logic [3:0] ALU_A, ALU_B, ALU_Out;

  int n_cmp = 0;
  int n_bad = 0;
  int m_rf  [4];
  int m_mem [32];
  logic [3:0] obs_a, obs_b, obs_out;

  alu_mem_datapath #(.WIDTH(W), .D_ADDR_W(5), .R_ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .D_addr(D_addr), .RF_W_addr(RF_W_addr),
    .RF_A_addr(RF_A_addr), .RF_B_addr(RF_B_addr), .D_wr(D_wr), .RF_s(RF_s),
    .RF_W_en(RF_W_en), .ALU_sel(ALU_sel), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_Out(ALU_Out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int alu_ref(input int op, input int a, input int b);
    case (op)
      0:  return 0;
      1:  return a;
      2:  return b;
      3:  return (a + b) % M;
      4:  return (a - b + M) % M;
      5:  return a & b;
      6:  return a | b;
      7:  return a ^ b;
      8:  return (M - 1) - a;
      9:  return (a + 1) % M;
      10: return (a + M - 1) % M;
      11: return (a * 2) % M;
      12: return a / 2;
      13: return a / 2 + ((a >= M / 2) ? M / 2 : 0);
      14: return (M - a) % M;
      default: return M - 1;
    endcase
  endfunction

  // One cycle: drive at negedge, check combinational outputs, clock, update model.
  task automatic cyc(input bit rst, input int da, input int wa, input int aa, input int ba,
                     input bit dwr, input bit rfs, input bit wen, input int op);
    int res, wd, old_a;
    rst_n = rst; D_addr = 5'(da); RF_W_addr = 2'(wa); RF_A_addr = 2'(aa);
    RF_B_addr = 2'(ba); D_wr = dwr; RF_s = rfs; RF_W_en = wen; ALU_sel = 4'(op);
    #1;
    obs_a = ALU_A; obs_b = ALU_B; obs_out = ALU_Out;
    res = alu_ref(op, m_rf[aa], m_rf[ba]);
    chk("port_A", obs_a, 4'(m_rf[aa]));
    chk("port_B", obs_b, 4'(m_rf[ba]));
    chk("alu_out", obs_out, 4'(res));
    wd    = rfs ? res : m_mem[da];
    old_a = m_rf[aa];
    if (!rst) begin
      for (int i = 0; i < 4; i++) m_rf[i] = 0;
    end else begin
      if (dwr) m_mem[da] = old_a;
      if (wen) m_rf[wa] = wd;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Read-only cycle used to observe a register.
  task automatic peek(input int r, input int op);
    cyc(1, 0, 0, r, r, 0, 0, 0, op);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
    for (int i = 0; i < 4; i++) m_rf[i] = 0;
    rst_n = 0; D_addr = '0; RF_W_addr = '0; RF_A_addr = '0; RF_B_addr = '0;
    D_wr = 0; RF_s = 0; RF_W_en = 0; ALU_sel = '0;
    @(posedge clk);
    @(negedge clk);

    // 1. reset state
    cyc(1, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("rst_rf0", obs_a, 4'h0);
    chk("rst_alu_zero", obs_out, 4'h0);
    cyc(1, 0, 0, 2, 3, 0, 0, 0, 0);
    chk("rst_rf3", obs_b, 4'h0);

    // 2. register load via ALU
    cyc(1, 0, 2, 0, 0, 0, 1, 1, 15);
    peek(2, 1);
    chk("rf2_ones", obs_a, 4'hF);

    // 3. memory store/load through mem[17]
    for (int i = 0; i < 6; i++) cyc(1, 0, 1, 1, 1, 0, 1, 1, 9);
    cyc(1, 17, 0, 1, 0, 1, 0, 0, 0);
    cyc(1, 17, 3, 0, 0, 0, 0, 1, 0);
    peek(3, 1);
    chk("rf3_from_mem", obs_a, 4'h6);

    // 4. arithmetic wrap
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 9);
    cyc(1, 0, 0, 2, 0, 0, 0, 0, 3);  chk("add_wrap", obs_out, 4'h0);
    cyc(1, 0, 0, 2, 0, 0, 0, 0, 4);  chk("sub_F_1", obs_out, 4'hE);
    cyc(1, 0, 3, 3, 3, 0, 1, 1, 9);
    cyc(1, 0, 3, 3, 3, 0, 1, 1, 9);
    cyc(1, 0, 0, 3, 0, 0, 0, 0, 13); chk("sra_8", obs_out, 4'hC);
    cyc(1, 0, 0, 3, 0, 0, 0, 0, 12); chk("shr_8", obs_out, 4'h4);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 14); chk("neg_1", obs_out, 4'hF);

    // 5. zero-fill sweep, then read every word back through rf[1]
    for (int r = 0; r < 4; r++) cyc(1, 0, r, 0, 0, 0, 1, 1, 0);
    for (int d = 0; d < 32; d++) cyc(1, d, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 1, 1, 15);
    for (int d = 0; d < 32; d++) cyc(1, d, 1, 1, 1, 0, 0, 1, 1);
    peek(1, 1);
    chk("zero_fill_last", obs_a, 4'h0);

    // 6. same-edge hazard: mem[5]=3, rf[0]=9
    for (int i = 0; i < 3; i++) cyc(1, 0, 2, 2, 2, 0, 1, 1, 9);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 0, 0, 1, 1, 9);
    cyc(1, 5, 0, 2, 0, 1, 0, 0, 0);
    cyc(1, 5, 1, 0, 0, 1, 0, 1, 0);
    peek(1, 1);
    chk("hazard_rf1_old_mem", obs_a, 4'h3);
    cyc(1, 5, 3, 0, 0, 0, 0, 1, 0);
    peek(3, 1);
    chk("hazard_mem5_old_A", obs_a, 4'h9);

    // reset overrides both writes at the same edge
    cyc(1, 5, 0, 2, 0, 1, 0, 0, 0);
    cyc(0, 5, 1, 0, 0, 1, 0, 1, 0);
    peek(0, 1);
    chk("rst_prio_rf0", obs_a, 4'h0);
    peek(1, 1);
    chk("rst_prio_rf1", obs_a, 4'h0);
    cyc(1, 5, 3, 0, 0, 0, 0, 1, 0);
    peek(3, 1);
    chk("rst_keeps_mem5", obs_a, 4'h3);

    // random cycles against the model
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 39) != 0), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
          int'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_mem_datapath.md
Name: alu_mem_datapath

Overview:
Single-clock datapath for the 16-bit non-RISC core. It contains a register file, a word-addressed data memory, a 16-function ALU, and a 2:1 write-back multiplexer. The controller drives all addresses, enables and the ALU opcode each cycle. The block exposes both register read ports and the ALU result for observation.

Parameters:
WIDTH, 16, data word width (ALU, memory, registers)
D_ADDR_W, 8, data-memory address width; depth 2**D_ADDR_W words
R_ADDR_W, 4, register-file address width; 2**R_ADDR_W registers

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  reset; synchronous, active-low
D_addr  in  D_ADDR_W  data-memory read/write address
RF_W_addr  in  R_ADDR_W  register-file write address
RF_A_addr  in  R_ADDR_W  register-file read port A address
RF_B_addr  in  R_ADDR_W  register-file read port B address
D_wr  in  1  memory write enable; writes port-A data to mem[D_addr]
RF_s  in  1  write-back select: 0 = memory read data, 1 = ALU result
RF_W_en  in  1  register-file write enable
ALU_sel  in  4  ALU opcode
ALU_A  out  WIDTH  register read data A (ALU operand A)
ALU_B  out  WIDTH  register read data B (ALU operand B)
ALU_Out  out  WIDTH  ALU result

Behaviour:
- Register file reads are combinational: A = rf[RF_A_addr], B = rf[RF_B_addr].
- Register file write: on a clk edge with rst_n=1 and RF_W_en=1, rf[RF_W_addr] <= RF_W.
- Write-back mux: RF_W = RF_s ? ALU result : mem read data.
- Memory read is combinational: rdata = mem[D_addr].
- Memory write: on a clk edge with rst_n=1 and D_wr=1, mem[D_addr] <= A.
- A read of a location written this cycle returns the old value. The new value is visible after the edge; there is no bypass.
- Simultaneous D_wr and RF_W_en with RF_s=0: the register file captures the pre-write memory word, and memory captures the pre-write A.
- Reset: on a clk edge with rst_n=0, all registers clear to 0.
  - Memory and register writes are suppressed during reset.
  - Memory contents are not cleared by reset.
  - After reset, ALU_A = ALU_B = 0 and ALU_Out = ALU_sel(0,0).
- Reset asserted mid-operation overrides any pending write at that edge.
- ALU is purely combinational. All results are truncated modulo 2**WIDTH, and shifts are by 1 bit. Opcodes:
  - 0 A_ZERO: 0
  - 1 A_PASSA: A
  - 2 A_PASSB: B
  - 3 A_ADD: A+B
  - 4 A_SUB: A-B
  - 5 A_AND: A&B
  - 6 A_OR: A|B
  - 7 A_XOR: A^B
  - 8 A_NOT: ~A
  - 9 A_INC: A+1
  - 10 A_DEC: A-1
  - 11 A_SHL: A<<1
  - 12 A_SHR: logical A>>1
  - 13 A_SRA: arithmetic A>>>1
  - 14 A_NEG: -A
  - 15 A_ONES: all ones
- ALU status signals (carry-out, signed overflow, error, A==B) are computed internally but not exported.
- All address values are in range; the full address space is usable with no wrap logic. X on inputs has no defined behaviour.

Decomposition:
- Shared package holds the ALU opcode constants (A_ZERO through A_ONES) as a 4-bit typedef alu_op_t.
- One sub-module is natural: dp_alu (combinational ALU with status flags).
- Register file, memory and mux are coded inline.

Test Plan:
Run all scenarios with WIDTH=4, D_ADDR_W=5, R_ADDR_W=2.
1. Reset: rst_n=0 for 1 edge, then read all 4 registers via A/B ports -> all 0. With ALU_sel=A_ZERO, ALU_Out=0.
2. Register load via ALU: RF_s=1, ALU_sel=A_ONES, RF_W_en=1, RF_W_addr=2, one edge -> rf[2]=4'hF. Then RF_A_addr=2 -> ALU_A=F.
3. Memory store/load: rf[1]=4'h6, RF_A_addr=1, D_addr=17, D_wr=1, one edge. Then D_wr=0, RF_s=0, RF_W_en=1, RF_W_addr=3, one edge -> rf[3]=6.
4. Arithmetic wrap: A=F, B=1. A_ADD -> 0; A_SUB -> E; A_SRA on A=8 -> C; A_SHR on 8 -> 4; A_NEG on 1 -> F.
5. Zero-fill sweep: A_ZERO written to all registers, then D_wr=1 with A=0 over D_addr 0..31 -> every mem word reads 0.
6. Same-edge hazard and reset priority:
   - mem[5]=3, rf[0]=9, D_addr=5, D_wr=1, RF_s=0, RF_W_en=1, RF_W_addr=1, one edge -> rf[1]=3, mem[5]=9.
   - Repeating the same setup with rst_n=0 -> no writes occur and registers read 0.
